// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one req/ack read per
// fetch enable, latches the returned word and flags timeouts/overruns.
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 15
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_enfetch,
  input  logic              I_pc_load,
  input  logic [ADDR_W-1:0] I_pc_target,
  output logic              O_imem_req,
  output logic [ADDR_W-1:0] O_imem_addr,
  input  logic              I_imem_ack,
  input  logic [DATA_W-1:0] I_imem_rdata,
  output logic [DATA_W-1:0] O_instr,
  output logic [ADDR_W-1:0] O_instr_pc,
  output logic              O_instr_valid,
  output logic              O_busy,
  output logic              O_fetch_err,
  output logic              O_overrun
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     cnt_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] ipc_q;
  logic              valid_q;
  logic              busy_q;
  logic              err_q;
  logic              ovr_q;
  logic              expire;

  // Wait budget is spent when this edge would be the TIMEOUT-th without ack
  assign expire = (int'(cnt_q) + 1) >= TIMEOUT;

  // Next PC: a branch/jump load wins over the post-fetch increment
  always_comb begin
    pc_d = pc_q;
    if (I_pc_load) begin
      pc_d = I_pc_target;
    end else if (state_q == S_WAIT && I_imem_ack) begin
      pc_d = addr_q + 1'b1;
    end
  end

  // Fetch FSM with all outputs registered
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_IDLE: begin
          if (I_enfetch) begin
            req_q   <= 1'b1;
            addr_q  <= pc_q;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (I_enfetch) begin
            ovr_q <= 1'b1;
          end
          if (I_imem_ack) begin
            instr_q <= I_imem_rdata;
            ipc_q   <= addr_q;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (expire) begin
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign O_imem_req    = req_q;
  assign O_imem_addr   = addr_q;
  assign O_instr       = instr_q;
  assign O_instr_pc    = ipc_q;
  assign O_instr_valid = valid_q;
  assign O_busy        = busy_q;
  assign O_fetch_err   = err_q;
  assign O_overrun     = ovr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus randomized fetches
// checked against a transaction-level model of PC and output state.
module tb_instr_fetch_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pcl;
  logic [15:0] tgt;
  logic        req;
  logic [15:0] addr;
  logic        ack;
  logic [15:0] rdata;
  logic [15:0] instr;
  logic [15:0] ipc;
  logic        valid;
  logic        busy;
  logic        err;
  logic        ovr;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_ipc;
  bit          m_valid;
  bit          m_err;
  bit          m_ovr;

  instr_fetch_unit #(
    .ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .TIMEOUT(TO)
  ) dut (
    .I_clk(clk),
    .I_reset(rst),
    .I_enfetch(en),
    .I_pc_load(pcl),
    .I_pc_target(tgt),
    .O_imem_req(req),
    .O_imem_addr(addr),
    .I_imem_ack(ack),
    .I_imem_rdata(rdata),
    .O_instr(instr),
    .O_instr_pc(ipc),
    .O_instr_valid(valid),
    .O_busy(busy),
    .O_fetch_err(err),
    .O_overrun(ovr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 16'h0000;
    m_instr = 16'h0000;
    m_ipc   = 16'h0000;
    m_valid = 0;
    m_err   = 0;
    m_ovr   = 0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_valid"}, valid, m_valid);
    chk({tag, "_instr"}, instr, m_instr);
    chk({tag, "_ipc"}, ipc, m_ipc);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_ovr"}, ovr, m_ovr);
  endtask

  task automatic load(input logic [15:0] t);
    pcl = 1;
    tgt = t;
    tick();
    pcl = 0;
    m_pc = t;
    chk("load_idle_busy", busy, 0);
  endtask

  // delay: edges after enable until ack (> TO means never acked)
  // load_k: WAIT edge carrying a PC load (0 = none)
  task automatic fetch(input int delay, input logic [15:0] rd,
                       input int load_k, input logic [15:0] ld_t,
                       input bit ovr_pulse);
    logic [15:0] a;
    int          fin;
    bit          ok;
    a   = m_pc;
    ok  = delay <= TO;
    fin = ok ? delay : TO;
    en = 1;
    tick();
    en = 0;
    m_valid = 0;
    chk("req_on", req, 1);
    chk("addr", addr, a);
    chk("busy_on", busy, 1);
    chk("valid_clr", valid, 0);
    for (int k = 1; k <= fin; k++) begin
      ack   = ok && (k == fin);
      rdata = ack ? rd : 16'($urandom);
      pcl   = (k == load_k);
      tgt   = ld_t;
      en    = ovr_pulse && (k == 1);
      tick();
      ack = 0;
      pcl = 0;
      en  = 0;
      if (k < fin) begin
        chk("req_hold", req, 1);
        chk("addr_hold", addr, a);
        chk("busy_hold", busy, 1);
      end
    end
    if (ovr_pulse) m_ovr = 1;
    if (ok) begin
      m_instr = rd;
      m_ipc   = a;
      m_valid = 1;
      m_pc    = (load_k == fin) ? ld_t : a + 16'd1;
    end else begin
      m_err = 1;
      if (load_k >= 1) m_pc = ld_t;
    end
    chk("req_off", req, 0);
    chk("busy_off", busy, 0);
    chk_outs("done");
  endtask

  initial begin
    int d;
    int lk;
    rst   = 1;
    en    = 0;
    pcl   = 0;
    tgt   = 0;
    ack   = 0;
    rdata = 0;
    model_reset();
    #3;
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    chk_outs("rst");
    @(negedge clk);
    rst = 0;
    tick();

    fetch(1, 16'h1234, 0, 0, 0);
    chk("pc_after_first", m_pc, 16'h0001);

    load(16'h0000);
    fetch(3, 16'hA001, 0, 0, 0);
    fetch(3, 16'hA002, 0, 0, 0);
    fetch(3, 16'hA003, 0, 0, 0);

    fetch(TO, 16'h5A5A, 0, 0, 0);
    chk("ack_at_expiry_no_err", err, 0);
    fetch(TO + 5, 16'h0000, 0, 0, 0);
    chk("timeout_err", err, 1);
    fetch(2, 16'h0BAD, 0, 0, 0);

    load(16'hFFFF);
    fetch(1, 16'hC0DE, 0, 0, 0);
    fetch(2, 16'hC0DF, 0, 0, 0);
    load(16'hFFFF);
    fetch(2, 16'hD00D, 2, 16'h0040, 0);
    fetch(1, 16'hD00E, 0, 0, 0);

    fetch(3, 16'hE001, 0, 0, 1);
    chk("overrun_set", ovr, 1);
    fetch(1, 16'hE002, 0, 0, 1);
    fetch(2, 16'hE003, 0, 0, 0);
    chk("overrun_sticky", ovr, 1);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3) == 0) load(16'($urandom));
      d  = $urandom_range(1, 18);
      lk = 0;
      if ($urandom_range(4) == 0)
        lk = $urandom_range(1, (d <= TO) ? d : TO);
      fetch(d, 16'($urandom), lk, 16'($urandom),
            $urandom_range(5) == 0);
      if ($urandom_range(1) == 0) tick();
    end

    en = 1;
    tick();
    en = 0;
    tick();
    tick();
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("async_req", req, 0);
    chk("async_busy", busy, 0);
    chk("async_addr", addr, 0);
    chk_outs("async");
    @(negedge clk);
    rst   = 0;
    ack   = 1;
    rdata = 16'hBEEF;
    tick();
    ack = 0;
    chk("late_ack_req", req, 0);
    chk("late_ack_busy", busy, 0);
    chk_outs("late_ack");
    fetch(2, 16'h7777, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
